io_bus_master: RTL and testbench

IO_BUS_MASTER -- requirements
Module: io_bus_master

---
 rtl/io_bus_master_pkg.sv | 22 ++
 rtl/io_cmd_fifo.sv | 56 +++++
 rtl/io_bus_master.sv | 141 ++++++++++++++
 tb/tb_io_bus_master.sv | 240 ++++++++++++++++++++++++
 4 files changed

// File: rtl/io_bus_master_pkg.sv
// Shared types for the IO bus master: FSM state encoding, bus widths and
// the command record stored in the command FIFO.
package io_bus_master_pkg;

  localparam int IO_ADDR_W = 16;
  localparam int IO_DATA_W = 16;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_WAIT  = 2'd2,
    ST_RESP  = 2'd3
  } state_e;

  // 33-bit FIFO entry: {write flag, address, write data}
  typedef struct packed {
    logic                 wr;
    logic [IO_ADDR_W-1:0] addr;
    logic [IO_DATA_W-1:0] data;
  } cmd_t;

endpackage

// File: rtl/io_cmd_fifo.sv
// Command FIFO for the IO bus master.
// Ports:
//   clk, rst          : clock, synchronous active-high reset (empties FIFO)
//   push_i / din_i    : push request and entry; ignored while full
//   pop_i  / dout_o   : pop request and head entry; ignored while empty
//   full_o / empty_o  : occupancy flags
module io_cmd_fifo
  import io_bus_master_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic push_i,
  input  cmd_t din_i,
  input  logic pop_i,
  output cmd_t dout_o,
  output logic full_o,
  output logic empty_o
);

  localparam int AW = $clog2(DEPTH);

  cmd_t          mem_q [DEPTH];
  logic [AW-1:0] wr_ptr_q, rd_ptr_q;
  logic [AW:0]   cnt_q;
  logic          do_push, do_pop;

  assign full_o  = (cnt_q == (AW+1)'(DEPTH));
  assign empty_o = (cnt_q == '0);
  // A full FIFO refuses the push even when the head is popped this cycle.
  assign do_push = push_i && !full_o;
  assign do_pop  = pop_i && !empty_o;
  assign dout_o  = mem_q[rd_ptr_q];

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
    end else begin
      if (do_push) begin
        mem_q[wr_ptr_q] <= din_i;
        wr_ptr_q        <= wr_ptr_q + 1'b1;
      end
      if (do_pop) rd_ptr_q <= rd_ptr_q + 1'b1;
      case ({do_push, do_pop})
        2'b10:   cnt_q <= cnt_q + 1'b1;
        2'b01:   cnt_q <= cnt_q - 1'b1;
        default: ;
      endcase
    end
  end

endmodule

// File: rtl/io_bus_master.sv
// IO bus master: queues write/read commands and replays them in order as
// single-cycle strobes on a simple IO bus; read data returns as a one-cycle
// rsp_valid pulse.
// Ports:
//   clk, rst                          : clock, synchronous active-high reset
//   cmd_valid/cmd_ready               : command handshake (ready = FIFO not full)
//   cmd_write/cmd_addr/cmd_wdata      : command payload
//   rsp_valid/rsp_rdata               : read response (data held between pulses)
//   busy                              : FIFO non-empty or FSM not idle
//   io_address/io_write_value         : registered IO bus address/data
//   io_write_en/io_read_en            : registered one-cycle strobes
//   io_read_value                     : responder read data, valid RD_LAT after strobe
module io_bus_master
  import io_bus_master_pkg::*;
#(
  parameter int DEPTH  = 4,
  parameter int RD_LAT = 1
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 cmd_valid,
  output logic                 cmd_ready,
  input  logic                 cmd_write,
  input  logic [IO_ADDR_W-1:0] cmd_addr,
  input  logic [IO_DATA_W-1:0] cmd_wdata,
  output logic                 rsp_valid,
  output logic [IO_DATA_W-1:0] rsp_rdata,
  output logic                 busy,
  output logic [IO_ADDR_W-1:0] io_address,
  output logic [IO_DATA_W-1:0] io_write_value,
  input  logic [IO_DATA_W-1:0] io_read_value,
  output logic                 io_write_en,
  output logic                 io_read_en
);

  state_e               state_q, state_d;
  logic [1:0]           cnt_q, cnt_d;
  logic                 cmd_wr_q, cmd_wr_d;
  logic [IO_ADDR_W-1:0] addr_q, addr_d;
  logic [IO_DATA_W-1:0] wval_q, wval_d;
  logic                 wen_q, wen_d, ren_q, ren_d;
  logic                 rsp_valid_q, rsp_valid_d;
  logic [IO_DATA_W-1:0] rdata_q, rdata_d;

  cmd_t fifo_din, fifo_head;
  logic fifo_full, fifo_empty, pop;

  assign fifo_din = '{wr: cmd_write, addr: cmd_addr, data: cmd_wdata};

  io_cmd_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .push_i  (cmd_valid),
    .din_i   (fifo_din),
    .pop_i   (pop),
    .dout_o  (fifo_head),
    .full_o  (fifo_full),
    .empty_o (fifo_empty)
  );

  // The command register is {cmd_wr_q, addr_q, wval_q}; it is loaded at the
  // pop so the bus outputs come straight from flops during ISSUE.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    cmd_wr_d    = cmd_wr_q;
    addr_d      = addr_q;
    wval_d      = wval_q;
    wen_d       = 1'b0;
    ren_d       = 1'b0;
    rsp_valid_d = 1'b0;
    rdata_d     = rdata_q;
    pop         = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (!fifo_empty) begin
          pop      = 1'b1;
          cmd_wr_d = fifo_head.wr;
          addr_d   = fifo_head.addr;
          // Write data only moves on writes so it holds across reads.
          if (fifo_head.wr) begin
            wval_d = fifo_head.data;
            wen_d  = 1'b1;
          end else begin
            ren_d  = 1'b1;
          end
          state_d = ST_ISSUE;
        end
      end
      ST_ISSUE: begin
        cnt_d   = '0;
        state_d = cmd_wr_q ? ST_IDLE : ST_WAIT;
      end
      ST_WAIT: begin
        if (cnt_q == 2'(RD_LAT - 1)) begin
          rdata_d     = io_read_value;
          rsp_valid_d = 1'b1;
          state_d     = ST_RESP;
        end else begin
          cnt_d = cnt_q + 2'd1;
        end
      end
      ST_RESP: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      cnt_q       <= '0;
      cmd_wr_q    <= 1'b0;
      addr_q      <= '0;
      wval_q      <= '0;
      wen_q       <= 1'b0;
      ren_q       <= 1'b0;
      rsp_valid_q <= 1'b0;
      rdata_q     <= '0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      cmd_wr_q    <= cmd_wr_d;
      addr_q      <= addr_d;
      wval_q      <= wval_d;
      wen_q       <= wen_d;
      ren_q       <= ren_d;
      rsp_valid_q <= rsp_valid_d;
      rdata_q     <= rdata_d;
    end
  end

  assign cmd_ready      = !fifo_full;
  assign busy           = !fifo_empty || (state_q != ST_IDLE);
  assign rsp_valid      = rsp_valid_q;
  assign rsp_rdata      = rdata_q;
  assign io_address     = addr_q;
  assign io_write_value = wval_q;
  assign io_write_en    = wen_q;
  assign io_read_en     = ren_q;

endmodule

// File: tb/tb_io_bus_master.sv
// Bench for io_bus_master: registered-read responder (switches, buttons,
// LEDs), a queue-based reference of accepted commands and expected responses,
// directed timing cases and a randomized command stream.
module tb_io_bus_master;

  localparam int DEPTH  = 4;
  localparam int RD_LAT = 1;

  logic        clk = 1'b0;
  logic        rst;
  logic        cmd_valid, cmd_ready, cmd_write;
  logic [15:0] cmd_addr, cmd_wdata;
  logic        rsp_valid;
  logic [15:0] rsp_rdata;
  logic        busy;
  logic [15:0] io_address, io_write_value;
  logic [15:0] io_read_value = '0;
  logic        io_write_en, io_read_en;

  io_bus_master #(.DEPTH(DEPTH), .RD_LAT(RD_LAT)) dut (
    .clk(clk), .rst(rst),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
    .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata),
    .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .busy(busy),
    .io_address(io_address), .io_write_value(io_write_value),
    .io_read_value(io_read_value),
    .io_write_en(io_write_en), .io_read_en(io_read_en)
  );

  always #5 clk = ~clk;

  int checks = 0, failures = 0;

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  // Responder
  logic [15:0] sw = '0, leds = '0;
  logic [4:0]  btn = '0;

  function automatic logic [15:0] rd_model(input logic [15:0] a);
    case (a)
      16'h0001: return sw;
      16'h0002: return {btn, 11'b0};
      default:  return 16'h0000;
    endcase
  endfunction

  always @(posedge clk) begin
    if (io_read_en) io_read_value <= rd_model(io_address);
    if (io_write_en && io_address[2]) leds <= io_write_value;
  end

  // Reference model
  typedef struct { bit wr; bit [15:0] addr; bit [15:0] data; } ecmd_t;
  typedef struct { bit [15:0] val; int due; } ersp_t;
  ecmd_t exp_q[$];
  ersp_t rsp_q[$];

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int wr_cnt = 0, rd_cnt = 0, rsp_cnt = 0;
  int last_wr = -1, last_rd = -1, last_rsp = -1;
  bit mon_on = 0, seen_full = 0;
  int full_occ = -1;
  logic [15:0] prev_addr, prev_wval;

  task automatic monitor();
    ecmd_t e;
    ersp_t r;
    if (rst || !mon_on) begin
      prev_addr = io_address;
      prev_wval = io_write_value;
      return;
    end
    if (io_write_en || io_read_en) begin
      chk("no_overlap", 32'(io_write_en && io_read_en), 0);
      if (io_write_en) begin wr_cnt++; last_wr = cyc; end
      else begin rd_cnt++; last_rd = cyc; end
      if (exp_q.size() == 0) chk("spurious_strobe", 1, 0);
      else begin
        e = exp_q.pop_front();
        chk("strobe_kind", 32'(io_write_en), 32'(e.wr));
        chk("strobe_addr", 32'(io_address), 32'(e.addr));
        if (e.wr) chk("strobe_wdata", 32'(io_write_value), 32'(e.data));
        else rsp_q.push_back('{rd_model(e.addr), cyc + RD_LAT + 1});
      end
    end else begin
      chk("addr_hold", 32'(io_address), 32'(prev_addr));
    end
    if (!io_write_en) chk("wval_hold", 32'(io_write_value), 32'(prev_wval));
    prev_addr = io_address;
    prev_wval = io_write_value;
    if (rsp_valid) begin
      rsp_cnt++; last_rsp = cyc;
      if (rsp_q.size() == 0) chk("spurious_rsp", 1, 0);
      else begin
        r = rsp_q.pop_front();
        chk("rsp_data", 32'(rsp_rdata), 32'(r.val));
        chk("rsp_latency", cyc, r.due);
      end
    end
    if (!cmd_ready && !seen_full) begin
      seen_full = 1;
      full_occ  = exp_q.size();
    end
    if (cmd_valid && cmd_ready) exp_q.push_back('{cmd_write, cmd_addr, cmd_wdata});
  endtask

  initial forever begin
    @(negedge clk);
    monitor();
  end

  // Stimulus helpers: all start and end at posedge+1
  task automatic send(input bit wr, input logic [15:0] a, input logic [15:0] d, output int acc);
    int n;
    n = 0;
    cmd_valid = 1'b1; cmd_write = wr; cmd_addr = a; cmd_wdata = d;
    @(negedge clk);
    while (!cmd_ready && n < 200) begin n++; @(negedge clk); end
    if (!cmd_ready) chk("send_timeout", 0, 1);
    acc = cyc;
    @(posedge clk); #1;
    cmd_valid = 1'b0;
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    @(negedge clk);
    while ((busy || exp_q.size() != 0 || rsp_q.size() != 0) && n < 2000) begin
      n++; @(negedge clk);
    end
    chk("idle_reached", 32'(busy || exp_q.size() != 0 || rsp_q.size() != 0), 0);
    @(posedge clk); #1;
  endtask

  initial begin
    int acc, w0, r0, s0;
    bit  wr;
    logic [15:0] a;
    int k;
    rst = 1'b1; cmd_valid = 1'b0; cmd_write = 1'b0; cmd_addr = '0; cmd_wdata = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_cmd_ready", 32'(cmd_ready), 1);
    chk("rst_rsp_valid", 32'(rsp_valid), 0);
    chk("rst_rsp_rdata", 32'(rsp_rdata), 0);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_io_address", 32'(io_address), 0);
    chk("rst_io_wval", 32'(io_write_value), 0);
    chk("rst_io_wen", 32'(io_write_en), 0);
    chk("rst_io_ren", 32'(io_read_en), 0);
    @(posedge clk); #1;
    rst = 1'b0; mon_on = 1;

    // Single write, empty FIFO
    w0 = wr_cnt; s0 = rsp_cnt;
    send(1'b1, 16'h0004, 16'hA5A5, acc);
    wait_idle();
    chk("wr_strobe_lat", last_wr - acc, 2);
    chk("wr_strobe_count", wr_cnt - w0, 1);
    chk("leds_after_wr", 32'(leds), 32'hA5A5);
    chk("wr_no_rsp", rsp_cnt - s0, 0);

    // Single read, empty FIFO
    sw = 16'h1234; btn = 5'b10101;
    send(1'b0, 16'h0001, 16'h0, acc);
    wait_idle();
    chk("rd_strobe_lat", last_rd - acc, 2);
    chk("rd_rsp_lat", last_rsp - acc, 4);
    chk("rd_rdata", 32'(rsp_rdata), 32'h1234);

    // Fill the FIFO with reads while the FSM is busy
    seen_full = 0; r0 = rd_cnt; s0 = rsp_cnt;
    for (int i = 0; i < 5; i++) send(1'b0, (i % 2 == 0) ? 16'h0001 : 16'h0002, 16'h0, acc);
    wait_idle();
    chk("full_seen", 32'(seen_full), 1);
    chk("full_occupancy", full_occ, DEPTH);
    chk("fill_reads_done", rd_cnt - r0, 5);
    chk("fill_rsps_done", rsp_cnt - s0, 5);

    // Read / write / read interleave
    s0 = rsp_cnt;
    send(1'b0, 16'h0001, 16'h0, acc);
    send(1'b1, 16'h0004, 16'h5A5A, acc);
    send(1'b0, 16'h0002, 16'h0, acc);
    wait_idle();
    chk("mix_rsp_count", rsp_cnt - s0, 2);
    chk("mix_last_rdata", 32'(rsp_rdata), 32'hA800);
    chk("mix_leds", 32'(leds), 32'h5A5A);

    // Randomized stream
    sw = 16'($urandom); btn = 5'($urandom);
    for (int i = 0; i < 60; i++) begin
      k  = int'($urandom_range(0, 3));
      a  = (k == 0) ? 16'h0001 : (k == 1) ? 16'h0002 : (k == 2) ? 16'h0004 : 16'($urandom);
      wr = ($urandom_range(0, 1) == 1);
      send(wr, a, 16'($urandom), acc);
      repeat ($urandom_range(0, 2)) @(posedge clk);
      #1;
    end
    wait_idle();

    // Reset during WAIT of the second read with three commands queued
    r0 = rd_cnt;
    send(1'b0, 16'h0001, 16'h0, acc);
    send(1'b0, 16'h0002, 16'h0, acc);
    send(1'b1, 16'h0004, 16'h1111, acc);
    send(1'b0, 16'h0001, 16'h0, acc);
    send(1'b1, 16'h0004, 16'h2222, acc);
    repeat (2) @(posedge clk);
    #1;
    chk("pre_rst_reads", rd_cnt - r0, 2);
    chk("pre_rst_busy", 32'(busy), 1);
    mon_on = 0; rst = 1'b1;
    exp_q.delete(); rsp_q.delete();
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0; mon_on = 1;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      chk("post_rst_strobe", 32'(io_write_en || io_read_en), 0);
      chk("post_rst_rsp", 32'(rsp_valid), 0);
      chk("post_rst_busy", 32'(busy), 0);
      chk("post_rst_ready", 32'(cmd_ready), 1);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
